param_update_engine: RTL and testbench

- Parametrised successor to the single-lane parameter-update FSM: streams COUNT elements of a parameter region and a gradient region from memory.
- Computes a fixed-point SGD update per element, with optional L2 weight decay, and writes the result back in place over the parameter region.
- Sits between the instruction dispatcher (go/done) and the memory arbiter (request/ack channels).

---
 rtl/param_update_engine_if.sv | 35 +++
 rtl/param_update_engine.sv | 201 ++++++++++++++++++++
 tb/tb_param_update_engine.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_update_engine_if.sv
// Memory-side bus of the parameter update engine: the parameter read,
// gradient read and write-back channels, each a req/ack handshake.
//   master : engine side (drives req/addr/wr_data, receives ack/rd_data)
//   slave  : memory arbiter side
interface param_update_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              p_rd_req;
  logic [ADDR_W-1:0] p_rd_addr;
  logic              p_rd_ack;
  logic [DATA_W-1:0] p_rd_data;

  logic              g_rd_req;
  logic [ADDR_W-1:0] g_rd_addr;
  logic              g_rd_ack;
  logic [DATA_W-1:0] g_rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (
    output p_rd_req, p_rd_addr, input p_rd_ack, p_rd_data,
    output g_rd_req, g_rd_addr, input g_rd_ack, g_rd_data,
    output wr_req, wr_addr, wr_data, input wr_ack
  );

  modport slave (
    input p_rd_req, p_rd_addr, output p_rd_ack, p_rd_data,
    input g_rd_req, g_rd_addr, output g_rd_ack, g_rd_data,
    input wr_req, wr_addr, wr_data, output wr_ack
  );
endinterface

// File: rtl/param_update_engine.sv
// Parameter update engine: streams count elements of a parameter region and
// a gradient region, applies a fixed-point SGD step (optionally with L2
// weight decay) and writes the result back over the parameter region.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   go_i, mode_i             start pulse (IDLE only), 0=SGD 1=SGD+decay
//   param_base_i, grad_base_i, count_i, lr_i, wd_i   run config, latched on go
//   busy_o, done_o           run in progress / one-cycle completion pulse
//   mem                      parameter/gradient read and write-back channels
module param_update_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] param_base_i,
  input  logic [ADDR_W-1:0] grad_base_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [DATA_W-1:0] lr_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic              busy_o,
  output logic              done_o,
  param_update_engine_if.master mem
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] COMPUTE = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int SW = DATA_W + 2;  // width of intermediate sums

  logic [2:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] pbase_q, pbase_d, gbase_q, gbase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx_q, idx_d;
  logic [DATA_W-1:0] lr_q, lr_d, wd_q, wd_d;
  logic [DATA_W-1:0] w_q, w_d, g_q, g_d;
  logic              p_got_q, p_got_d, g_got_q, g_got_d;
  logic              p_req_q, p_req_d, g_req_q, g_req_d, wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d, g_addr_q, g_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Datapath: full-width products, floor shifts, DATA_W+2 bit sums and a
  // single saturation at the end.
  logic signed [2*DATA_W-1:0]  wd_prod;
  logic signed [SW-1:0]        upd;
  logic signed [DATA_W+SW-1:0] lr_prod;
  logic signed [SW-1:0]        res;
  logic [DATA_W-1:0]           sat;

  always_comb begin
    wd_prod = $signed(wd_q) * $signed(w_q);
    upd     = {{2{g_q[DATA_W-1]}}, g_q};
    if (mode_q) upd = upd + SW'(wd_prod >>> FRAC_W);
    lr_prod = $signed(lr_q) * upd;
    res     = {{2{w_q[DATA_W-1]}}, w_q} - SW'(lr_prod >>> FRAC_W);
    // In range when the bits above the DATA_W sign bit all match it.
    if (res[SW-1:DATA_W-1] == '0 || res[SW-1:DATA_W-1] == '1)
      sat = res[DATA_W-1:0];
    else if (res[SW-1])
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pbase_d   = pbase_q;
    gbase_d   = gbase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lr_d      = lr_q;
    wd_d      = wd_q;
    w_d       = w_q;
    g_d       = g_q;
    p_got_d   = p_got_q;
    g_got_d   = g_got_q;
    p_req_d   = p_req_q;
    g_req_d   = g_req_q;
    wr_req_d  = wr_req_q;
    p_addr_d  = p_addr_q;
    g_addr_d  = g_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (go_i) begin
        mode_d  = mode_i;
        pbase_d = param_base_i;
        gbase_d = grad_base_i;
        cnt_d   = count_i;
        lr_d    = lr_i;
        wd_d    = wd_i;
        idx_d   = '0;
        if (count_i == '0) begin
          state_d = DONE;
        end else begin
          state_d  = FETCH;
          p_req_d  = 1'b1;
          g_req_d  = 1'b1;
          p_addr_d = param_base_i;
          g_addr_d = grad_base_i;
          p_got_d  = 1'b0;
          g_got_d  = 1'b0;
        end
      end
      FETCH: begin
        // Channels complete independently; acks without req are ignored.
        if (p_req_q && mem.p_rd_ack) begin
          w_d = mem.p_rd_data; p_req_d = 1'b0; p_got_d = 1'b1;
        end
        if (g_req_q && mem.g_rd_ack) begin
          g_d = mem.g_rd_data; g_req_d = 1'b0; g_got_d = 1'b1;
        end
        if (p_got_d && g_got_d) state_d = COMPUTE;
      end
      COMPUTE: begin
        wr_data_d = sat;
        wr_addr_d = pbase_q + ADDR_W'(idx_q);
        wr_req_d  = 1'b1;
        state_d   = WRITE;
      end
      WRITE: if (wr_req_q && mem.wr_ack) begin
        wr_req_d = 1'b0;
        idx_d    = idx_q + 1'b1;
        if (idx_q == cnt_q - 1'b1) begin
          state_d = DONE;
        end else begin
          state_d  = FETCH;
          p_req_d  = 1'b1;
          g_req_d  = 1'b1;
          p_addr_d = pbase_q + ADDR_W'(idx_d);
          g_addr_d = gbase_q + ADDR_W'(idx_d);
          p_got_d  = 1'b0;
          g_got_d  = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      pbase_q   <= '0;
      gbase_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      lr_q      <= '0;
      wd_q      <= '0;
      w_q       <= '0;
      g_q       <= '0;
      p_got_q   <= 1'b0;
      g_got_q   <= 1'b0;
      p_req_q   <= 1'b0;
      g_req_q   <= 1'b0;
      wr_req_q  <= 1'b0;
      p_addr_q  <= '0;
      g_addr_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pbase_q   <= pbase_d;
      gbase_q   <= gbase_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lr_q      <= lr_d;
      wd_q      <= wd_d;
      w_q       <= w_d;
      g_q       <= g_d;
      p_got_q   <= p_got_d;
      g_got_q   <= g_got_d;
      p_req_q   <= p_req_d;
      g_req_q   <= g_req_d;
      wr_req_q  <= wr_req_d;
      p_addr_q  <= p_addr_d;
      g_addr_q  <= g_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy_o        = (state_q == FETCH) || (state_q == COMPUTE) || (state_q == WRITE);
  assign done_o        = (state_q == DONE);
  assign mem.p_rd_req  = p_req_q;
  assign mem.p_rd_addr = p_addr_q;
  assign mem.g_rd_req  = g_req_q;
  assign mem.g_rd_addr = g_addr_q;
  assign mem.wr_req    = wr_req_q;
  assign mem.wr_addr   = wr_addr_q;
  assign mem.wr_data   = wr_data_q;
endmodule

// File: tb/tb_param_update_engine.sv
module tb_param_update_engine;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          go, mode;
  logic [AW-1:0] pbase, gbase;
  logic [CW-1:0] cnt;
  logic [DW-1:0] lr, wd;
  logic          busy, done;

  param_update_engine_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  param_update_engine #(.DATA_W(DW), .FRAC_W(16), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .go_i(go), .mode_i(mode),
    .param_base_i(pbase), .grad_base_i(gbase), .count_i(cnt),
    .lr_i(lr), .wd_i(wd), .busy_o(busy), .done_o(done), .mem(mif.master)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];

  logic [DW-1:0] pmem [int];
  logic [DW-1:0] gmem [int];

  int chk = 0, err = 0;
  int cyc = 0, wr_cyc = -10, n_wr = 0, n_done = 0;
  int p_dly = 0, g_dly = 0, wr_dly = 0;
  bit wr_rand = 0, chk_lat = 0, any_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responders: ack after a programmable number of cycles, drop the
  // ack once the engine releases its request.
  initial begin
    int n = 0;
    mif.p_rd_ack = 1'b0; mif.p_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mif.p_rd_req && !mif.p_rd_ack) begin
        if (n >= p_dly) begin
          mif.p_rd_ack  = 1'b1;
          mif.p_rd_data = pmem.exists(int'(mif.p_rd_addr)) ? pmem[int'(mif.p_rd_addr)] : 32'hDEAD_BEEF;
          n = 0;
        end else n++;
      end else begin mif.p_rd_ack = 1'b0; n = 0; end
    end
  end

  initial begin
    int n = 0;
    mif.g_rd_ack = 1'b0; mif.g_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mif.g_rd_req && !mif.g_rd_ack) begin
        if (n >= g_dly) begin
          mif.g_rd_ack  = 1'b1;
          mif.g_rd_data = gmem.exists(int'(mif.g_rd_addr)) ? gmem[int'(mif.g_rd_addr)] : 32'hDEAD_BEEF;
          n = 0;
        end else n++;
      end else begin mif.g_rd_ack = 1'b0; n = 0; end
    end
  end

  initial begin
    int n = 0, tgt = 0;
    mif.wr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mif.wr_req && !mif.wr_ack) begin
        if (n == 0) tgt = wr_rand ? int'($urandom_range(0, 3)) : wr_dly;
        if (n >= tgt) begin
          mif.wr_ack = 1'b1;
          pmem[int'(mif.wr_addr)] = mif.wr_data;
          n = 0;
        end else n++;
      end else begin mif.wr_ack = 1'b0; n = 0; end
    end
  end

  // Monitor: scoreboard pops on every write handshake, checks req/addr hold,
  // done latency and busy during done.
  bit            pp, gp, wp;
  logic [AW-1:0] pa, ga, wa;
  logic [DW-1:0] wdat;
  always @(negedge clk) begin
    if (rst) begin
      pp = 0; gp = 0; wp = 0;
    end else begin
      if (pp) begin
        chk++;
        if (!mif.p_rd_req || mif.p_rd_addr !== pa) begin
          err++; $display("FAIL p_hold: req=%b addr=%h, want req=1 addr=%h", mif.p_rd_req, mif.p_rd_addr, pa);
        end
      end
      if (gp) begin
        chk++;
        if (!mif.g_rd_req || mif.g_rd_addr !== ga) begin
          err++; $display("FAIL g_hold: req=%b addr=%h, want req=1 addr=%h", mif.g_rd_req, mif.g_rd_addr, ga);
        end
      end
      if (wp) begin
        chk++;
        if (!mif.wr_req || mif.wr_addr !== wa || mif.wr_data !== wdat) begin
          err++; $display("FAIL wr_hold: req=%b addr=%h data=%h, want 1/%h/%h", mif.wr_req, mif.wr_addr, mif.wr_data, wa, wdat);
        end
      end
      if (mif.wr_req && mif.wr_ack) begin
        chk++;
        if (exp_q.size() == 0) begin
          err++; $display("FAIL wr_extra: addr=%h data=%h, want no write", mif.wr_addr, mif.wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mif.wr_addr !== e.addr || mif.wr_data !== e.data) begin
            err++; $display("FAIL wr_value: addr=%h data=%h, want addr=%h data=%h", mif.wr_addr, mif.wr_data, e.addr, e.data);
          end
        end
        n_wr++;
        wr_cyc = cyc;
      end
      if (done) begin
        n_done++;
        chk++;
        if (busy) begin err++; $display("FAIL busy_in_done: busy=%b, want 0", busy); end
        if (chk_lat) begin
          chk++;
          if (cyc != wr_cyc + 1) begin
            err++; $display("FAIL done_latency: done at cycle %0d, want %0d", cyc, wr_cyc + 1);
          end
        end
      end
      if (mif.p_rd_req || mif.g_rd_req || mif.wr_req) any_req = 1;
      pp = mif.p_rd_req && !mif.p_rd_ack; pa = mif.p_rd_addr;
      gp = mif.g_rd_req && !mif.g_rd_ack; ga = mif.g_rd_addr;
      wp = mif.wr_req && !mif.wr_ack;     wa = mif.wr_addr; wdat = mif.wr_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
    chk++;
    if (act !== want) begin err++; $display("FAIL %s: got %h, want %h", tag, act, want); end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic m, input logic [AW-1:0] pb, input logic [AW-1:0] gb,
                       input logic [CW-1:0] c, input logic [DW-1:0] l, input logic [DW-1:0] w);
    @(posedge clk); #1;
    go = 1'b1; mode = m; pbase = pb; gbase = gb; cnt = c; lr = l; wd = w;
    @(posedge clk); #1;
    go = 1'b0; mode = 1'bx; pbase = 'x; gbase = 'x; cnt = 'x; lr = 'x; wd = 'x;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (!done && k < budget);
    chk++;
    if (!done) begin
      err++; $display("FAIL %s: done=0 after %0d cycles, want done=1", tag, budget);
    end else begin
      @(negedge clk);
      chk++;
      if (done || busy) begin
        err++; $display("FAIL %s_pulse: done=%b busy=%b, want 0/0", tag, done, busy);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, nd;
    go = 1'b0; mode = 1'b0; pbase = '0; gbase = '0; cnt = '0; lr = '0; wd = '0;
    rst = 1'b1;
    #2;
    check("reset_ctl", {60'd0, busy, done, mif.p_rd_req, mif.g_rd_req}, 64'd0);
    check("reset_wr",  {15'd0, mif.wr_req, mif.wr_addr, mif.wr_data}, 64'd0);
    check("reset_rd_addr", {32'd0, mif.p_rd_addr, mif.g_rd_addr}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: plain SGD, both read acks in the same cycle.
    pmem.delete(); gmem.delete();
    pmem[16'h0010] = 32'h0002_0000; gmem[16'h0020] = 32'h0001_0000;
    expect_wr(16'h0010, 32'h0001_8000);
    chk_lat = 1;
    start(1'b0, 16'h0010, 16'h0020, 16'd1, 32'h0000_8000, 32'h0);
    @(negedge clk);
    check("busy_after_go", {63'd0, busy}, 64'd1);
    wait_done(100, "t1_done");

    // 2: weight decay, gradient ack before parameter ack; second element
    // exercises floor on negative products.
    pmem.delete(); gmem.delete();
    pmem[16'h0030] = 32'h0002_0000; gmem[16'h0040] = 32'h0001_0000;
    pmem[16'h0031] = 32'hFFFF_FFFF; gmem[16'h0041] = 32'h0000_0000;
    expect_wr(16'h0030, 32'h0001_0000);
    expect_wr(16'h0031, 32'h0000_0000);
    p_dly = 2; g_dly = 0;
    start(1'b1, 16'h0030, 16'h0040, 16'd2, 32'h0000_8000, 32'h0000_8000);
    wait_done(100, "t2_done");

    // 3: saturation at both ends.
    pmem.delete(); gmem.delete();
    pmem[16'h0050] = 32'h8000_0000; gmem[16'h0060] = 32'h7FFF_0000;
    pmem[16'h0051] = 32'h7FFF_FFFF; gmem[16'h0061] = 32'hFFFF_0000;
    expect_wr(16'h0050, 32'h8000_0000);
    expect_wr(16'h0051, 32'h7FFF_FFFF);
    p_dly = 0; g_dly = 1;
    start(1'b0, 16'h0050, 16'h0060, 16'd2, 32'h0001_0000, 32'h0);
    wait_done(100, "t3_done");

    // 4: streaming across the address wrap, skewed read acks, random write acks.
    pmem.delete(); gmem.delete();
    pmem[16'hFFFE] = 32'h0001_0000; gmem[16'h0100] = 32'h0002_0000;
    pmem[16'hFFFF] = 32'h0002_0000; gmem[16'h0101] = 32'hFFFE_0000;
    pmem[16'h0000] = 32'hFFFF_0000; gmem[16'h0102] = 32'h0001_0000;
    pmem[16'h0001] = 32'h0000_0000; gmem[16'h0103] = 32'h0000_4000;
    expect_wr(16'hFFFE, 32'h0000_0000);
    expect_wr(16'hFFFF, 32'h0003_0000);
    expect_wr(16'h0000, 32'hFFFE_8000);
    expect_wr(16'h0001, 32'hFFFF_E000);
    p_dly = 0; g_dly = 3; wr_rand = 1;
    start(1'b0, 16'hFFFE, 16'h0100, 16'd4, 32'h0000_8000, 32'h0);
    wait_done(300, "t4_done");
    wr_rand = 0; p_dly = 0; g_dly = 0;

    // 5a: count=0 completes without touching memory.
    any_req = 0; chk_lat = 0;
    start(1'b0, 16'h0070, 16'h0080, 16'd0, 32'h0000_8000, 32'h0);
    wait_done(2, "t5_zero_done");
    check("t5_no_req", {63'd0, any_req}, 64'd0);

    // 5b: go while busy is ignored.
    pmem.delete(); gmem.delete();
    pmem[16'h0200] = 32'h0003_0000; gmem[16'h0300] = 32'h0002_0000;
    pmem[16'h0201] = 32'h0004_0000; gmem[16'h0301] = 32'h0002_0000;
    expect_wr(16'h0200, 32'h0002_0000);
    expect_wr(16'h0201, 32'h0003_0000);
    nw = n_wr; chk_lat = 1;
    start(1'b0, 16'h0200, 16'h0300, 16'd2, 32'h0000_8000, 32'h0);
    repeat (2) @(posedge clk);
    start(1'b0, 16'h0500, 16'h0600, 16'd5, 32'h0001_0000, 32'h0);
    wait_done(100, "t5_busy_done");
    repeat (10) @(negedge clk);
    check("t5_write_count", 64'(n_wr - nw), 64'd2);
    check("t5_idle_after", {63'd0, busy}, 64'd0);

    // 6: reset during the write of element 1 of 3, then a clean rerun.
    pmem.delete(); gmem.delete();
    pmem[16'h0400] = 32'h0001_0000; gmem[16'h0410] = 32'h0002_0000;
    pmem[16'h0401] = 32'h0002_0000; gmem[16'h0411] = 32'h0002_0000;
    pmem[16'h0402] = 32'h0003_0000; gmem[16'h0412] = 32'h0002_0000;
    expect_wr(16'h0400, 32'h0000_0000);
    expect_wr(16'h0401, 32'h0001_0000);
    expect_wr(16'h0402, 32'h0002_0000);
    nw = n_wr; wr_dly = 20; chk_lat = 0;
    start(1'b0, 16'h0400, 16'h0410, 16'd3, 32'h0000_8000, 32'h0);
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!(n_wr - nw == 1 && mif.wr_req) && k < 500);
      check("t6_reach_write1", {63'd0, (n_wr - nw == 1 && mif.wr_req)}, 64'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ctl", {60'd0, busy, done, mif.p_rd_req, mif.g_rd_req}, 64'd0);
    check("t6_rst_wr",  {15'd0, mif.wr_req, mif.wr_addr, mif.wr_data}, 64'd0);
    nd = n_done;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wr_dly = 0;
    repeat (3) @(negedge clk);
    check("t6_no_done", 64'(n_done - nd), 64'd0);
    pmem[16'h0400] = 32'h0001_0000;
    expect_wr(16'h0400, 32'h0000_0000);
    expect_wr(16'h0401, 32'h0001_0000);
    nw = n_wr; chk_lat = 1;
    start(1'b0, 16'h0400, 16'h0410, 16'd2, 32'h0000_8000, 32'h0);
    wait_done(100, "t6_rerun_done");
    check("t6_rerun_writes", 64'(n_wr - nw), 64'd2);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
